// File: rtl/stacker_row_engine_if.sv
// Game-state bus of the stacker: tick and button pulses in, tower height, moving row and board out.
// The master side drives the tick/buttons; the slave side is the row engine.
interface stacker_row_engine_if #(
   parameter int WIDTH      = 8,
   parameter int MAX_HEIGHT = 10
);
   logic                        game_pulse;
   logic                        btn_start;
   logic                        btn_place;
   logic [3:0]                  height;
   logic [WIDTH-1:0]            row_pos;
   logic [WIDTH*MAX_HEIGHT-1:0] board;
   logic                        game_over;
   logic                        game_win;

   modport master (
      output game_pulse, btn_start, btn_place,
      input  height, row_pos, board, game_over, game_win
   );

   modport slave (
      input  game_pulse, btn_start, btn_place,
      output height, row_pos, board, game_over, game_win
   );
endinterface

// File: rtl/stacker_row_engine.sv
// Stacker game core: sweeps the segment, trims it on place, tracks height and win/lose; all outputs registered.
// A place lands two cycles after the press; there is no backpressure, pulses outside MOVE are dropped.
module stacker_row_engine #(
   parameter int WIDTH      = 8,
   parameter int MAX_HEIGHT = 10,
   parameter int INIT_LEN   = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   stacker_row_engine_if.slave  bus
);
   typedef enum logic [2:0] {S_IDLE, S_MOVE, S_PLACE, S_WIN, S_LOSE} state_t;
   typedef enum logic {DIR_LEFT, DIR_RIGHT} dir_t;

   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] INIT_SEG = ALL_ONES >> (WIDTH - INIT_LEN);

   state_t           state_q, state_d;
   dir_t             dir_q, dir_d;
   logic [3:0]       height_q, height_d;
   logic [WIDTH-1:0] row_q, row_d;
   logic [WIDTH-1:0] seg_q, seg_d;
   logic [WIDTH-1:0] prev_q, prev_d;
   logic [WIDTH-1:0] rows_q [MAX_HEIGHT];
   logic [WIDTH-1:0] rows_d [MAX_HEIGHT];
   logic             over_q, over_d;
   logic             win_q, win_d;

   logic [WIDTH-1:0] overlap;
   logic [3:0]       height_inc;

   assign overlap    = seg_q & prev_q;
   assign height_inc = height_q + 4'd1;

   always_comb begin
      state_d  = state_q;
      dir_d    = dir_q;
      height_d = height_q;
      row_d    = row_q;
      seg_d    = seg_q;
      prev_d   = prev_q;
      rows_d   = rows_q;
      over_d   = over_q;
      win_d    = win_q;
      unique case (state_q)
         S_IDLE, S_WIN, S_LOSE: begin
            if (bus.btn_start) begin
               state_d  = S_MOVE;
               rows_d   = '{default: '0};
               height_d = 4'd0;
               prev_d   = ALL_ONES;
               row_d    = INIT_SEG;
               dir_d    = DIR_LEFT;
               over_d   = 1'b0;
               win_d    = 1'b0;
            end
         end
         S_MOVE: begin
            // a place press freezes the pre-shift segment and swallows any same-cycle tick
            if (bus.btn_place) begin
               seg_d   = row_q;
               state_d = S_PLACE;
            end else if (bus.game_pulse) begin
               if (dir_q == DIR_LEFT) begin
                  if (row_q[WIDTH-1]) begin
                     dir_d = DIR_RIGHT;
                     row_d = row_q >> 1;
                  end else begin
                     row_d = row_q << 1;
                  end
               end else begin
                  if (row_q[0]) begin
                     dir_d = DIR_LEFT;
                     row_d = row_q << 1;
                  end else begin
                     row_d = row_q >> 1;
                  end
               end
            end
         end
         S_PLACE: begin
            if (overlap == '0) begin
               state_d = S_LOSE;
               over_d  = 1'b1;
            end else begin
               for (int r = 0; r < MAX_HEIGHT; r++) begin
                  if (4'(r) == height_q) rows_d[r] = overlap;
               end
               prev_d   = overlap;
               row_d    = overlap;
               height_d = height_inc;
               if (height_inc == 4'(MAX_HEIGHT)) begin
                  state_d = S_WIN;
                  win_d   = 1'b1;
               end else begin
                  state_d = S_MOVE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         dir_q    <= DIR_LEFT;
         height_q <= 4'd0;
         row_q    <= '0;
         seg_q    <= '0;
         prev_q   <= ALL_ONES;
         rows_q   <= '{default: '0};
         over_q   <= 1'b0;
         win_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         dir_q    <= dir_d;
         height_q <= height_d;
         row_q    <= row_d;
         seg_q    <= seg_d;
         prev_q   <= prev_d;
         rows_q   <= rows_d;
         over_q   <= over_d;
         win_q    <= win_d;
      end
   end

   for (genvar g = 0; g < MAX_HEIGHT; g++) begin : g_board
      assign bus.board[g*WIDTH +: WIDTH] = rows_q[g];
   end

   assign bus.height    = height_q;
   assign bus.row_pos   = row_q;
   assign bus.game_over = over_q;
   assign bus.game_win  = win_q;
endmodule
